// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// State encoding is fixed so external debug views stay stable.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_add_fa_cell.sv
// One-bit full adder shared by the serial controller; purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: LSB-first over WIDTH cycles through one fa_cell, done pulse on completion.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             fa_s, fa_cout;

  // Subtraction is a + ~b + 1, so only the captured B and initial carry change.
`ifdef SERIAL_ADD_SUB_EN
  always_comb begin
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load     = b;
    carry_load = cin;
  end
`endif

  fa_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
        end
      end
      S_LOAD: begin
        sum_sr_d = '0;
        cnt_d    = '0;
      end
      S_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        // On the MSB cycle carry_q is the carry into the MSB.
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          sum_d  = {fa_s, sum_sr_q[WIDTH-1:1]};
          cout_d = fa_cout;
          ovf_d  = carry_q ^ fa_cout;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == S_LOAD) || (state_q == S_SHIFT);
    done = (state_q == S_DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub_s;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_s),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum[7:0]} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic ci, input logic sb);
    logic [7:0] bb;
    logic       c;
    logic [8:0] full;
    logic       v;
    bb   = sb ? ~bv : bv;
    c    = sb ? 1'b1 : ci;
    full = {1'b0, av} + {1'b0, bb} + {8'd0, c};
    v    = (av[7] == bb[7]) && (full[7] != av[7]);
    return {v, full[8], full[7:0]};
  endfunction

  task automatic run_add(input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic sb, input string tag);
    int first_done, busy_n, done_n;
    logic [9:0] exp;
    logic [7:0] s_cap;
    logic c_cap, v_cap;
    exp = model(av, bv, ci, sb & HAS_SUB);
    @(posedge clk); #1;
    a = av; b = bv; cin = ci; sub_s = sb & HAS_SUB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_s = 1'($urandom) & HAS_SUB;
    first_done = -1; busy_n = 0; done_n = 0;
    s_cap = '0; c_cap = 1'b0; v_cap = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (first_done < 0) begin
          first_done = k;
          s_cap = sum; c_cap = cout; v_cap = ovf;
        end
      end
    end
    check({tag, " latency"}, first_done, W + 1);
    check({tag, " done_count"}, done_n, 1);
    check({tag, " busy_cycles"}, busy_n, W + 1);
    check({tag, " sum"}, {24'd0, s_cap}, {24'd0, exp[7:0]});
    check({tag, " cout"}, {31'd0, c_cap}, {31'd0, exp[8]});
    check({tag, " ovf"}, {31'd0, v_cap}, {31'd0, exp[9]});
    check({tag, " sum_held"}, {24'd0, sum}, {24'd0, exp[7:0]});
  endtask

  initial begin
    int dn, busy_seen;
    int done_at[$];
    logic [9:0] e;
    logic [7:0] s_cap;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_s = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst sum", {24'd0, sum}, 0);
    check("rst cout_ovf", {30'd0, cout, ovf}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_add(8'h05, 8'h03, 1'b0, 1'b0, "add_05_03");
    run_add(8'hFF, 8'h01, 1'b0, 1'b0, "add_FF_01");
    run_add(8'hFF, 8'h00, 1'b1, 1'b0, "add_FF_00_c");
    run_add(8'h7F, 8'h01, 1'b0, 1'b0, "add_7F_01");
    run_add(8'h80, 8'h80, 1'b0, 1'b0, "add_80_80");
    for (int i = 0; i < 20; i++)
      run_add(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand");

    // Reset two cycles in the middle of SHIFT.
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst busy", {31'd0, busy}, 0);
    check("midrst done", {31'd0, done}, 0);
    check("midrst sum", {24'd0, sum}, 0);
    check("midrst cout_ovf", {30'd0, cout, ovf}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    dn = 0; busy_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) busy_seen++;
    end
    check("midrst no_done", dn, 0);
    check("midrst no_busy", busy_seen, 0);

    // Second start while busy must be ignored.
    e = model(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h55; b = 8'h55; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; s_cap = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin dn++; s_cap = sum; end
    end
    check("ignore done_count", dn, 1);
    check("ignore sum", {24'd0, s_cap}, {24'd0, e[7:0]});

    // Start held high: one add every WIDTH+3 cycles.
    e = model(8'hA7, 8'h3C, 1'b1, 1'b0);
    @(posedge clk); #1;
    a = 8'hA7; b = 8'h3C; cin = 1'b1; start = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(k);
        check("held sum", {24'd0, sum}, {24'd0, e[7:0]});
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("held enough_dones", {31'd0, done_at.size() >= 3}, 1);
    for (int i = 1; i < done_at.size(); i++)
      check("held period", done_at[i] - done_at[i-1], W + 3);
    repeat (15) @(posedge clk);

`ifdef SERIAL_ADD_SUB_EN
    run_add(8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07");
    run_add(8'h07, 8'h05, 1'b1, 1'b1, "sub_07_05");
    for (int i = 0; i < 6; i++)
      run_add(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "rand_sub");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
